// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial link: receiver state encoding and
// the default link geometry used by both the serializer and deserializer.
package serial_rx_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Default link geometry, kept identical on both ends of the link.
    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam int DEFAULT_DATA_WIDTH   = 8;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : serial_rx_pkg

// File: rtl/serial_rx_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input. The reset value
// is a parameter so idle-high lines do not look active coming out of reset.
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule : bit_sync

// File: rtl/serial_rx.sv
// Deserializer for the 8-bit serial link. Recovers start/data/stop frames
// (data LSB-first) from an idle-high line and presents each word on a
// one-entry valid/ready buffer, with one-cycle frame error and overrun pulses.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for a low level on the synchronized line
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling DATA_WIDTH data bits at their centres, LSB first
// STOP  | sampling the stop bit, then delivering, dropping or flagging
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = cnt_width(DATA_WIDTH);

    // Start bit is checked half a bit in; data and stop bits a full bit apart.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_WIDTH - 1);

    logic                  rx_s;

    rx_state_e             state_q,     state_d;
    logic [CNT_W-1:0]      clk_cnt_q,   clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;

    // The line is idle high, so the synchronizer resets to 1.
    bit_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (rx_in),
        .q_out (rx_s)
    );

    // Next-state logic for the frame FSM and the output buffer.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer pop; a word loaded in STOP below overrides this.
        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end

            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    if (rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        clk_cnt_d = '0;
                        bit_cnt_d = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    clk_cnt_d = '0;
                    if (bit_cnt_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || ready_in) begin
                        // Buffer empty or being drained on this same edge.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule : serial_rx

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: directed frames plus randomized traffic, compared every
// cycle against a frame-level model (stop-bit outcome at a fixed latency after
// the start edge, one-entry buffer with valid/ready).
module tb_serial_rx;

    localparam int CPB = 4;
    localparam int DW  = 8;
    // Stop-bit sample edge, counted from the edge after which the start bit is driven.
    localparam int STOP_LAT = (DW + 1) * CPB + CPB / 2 + 3;

    logic          clk;
    logic          rst_n;
    logic          rx_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          frame_err;
    logic          overrun;

    serial_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [DW-1:0] data;
        logic        stop;
    } frame_t;

    frame_t        pend_q[$];
    int            cyc;
    int            n_cmp;
    int            n_err;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ferr;
    logic          m_ovr;
    logic          rand_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        pend_q.delete();
    endtask

    // One clock: advance the model at the edge, then compare 1 time unit later.
    task automatic tick();
        logic   pre_valid;
        logic   rdy;
        frame_t ev;
        @(posedge clk);
        cyc++;
        rdy       = ready_in;
        pre_valid = m_valid;
        m_ferr    = 1'b0;
        m_ovr     = 1'b0;
        if (!rst_n) begin
            model_clear();
        end else begin
            if (pre_valid && rdy) m_valid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
                ev = pend_q.pop_front();
                if (!ev.stop) begin
                    m_ferr = 1'b1;
                end else if (!pre_valid || rdy) begin
                    m_valid = 1'b1;
                    m_data  = ev.data;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        #1;
        check("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
        check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
        check("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
        if (m_valid) check("data_out", {24'd0, data_out}, {24'd0, m_data});
        if (rand_ready) ready_in = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
        frame_t f;
        f.cyc  = cyc + STOP_LAT;
        f.data = d;
        f.stop = stop_bit;
        pend_q.push_back(f);
        rx_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < DW; i++) begin
            rx_in = d[i];
            repeat (CPB) tick();
        end
        rx_in = stop_bit;
        repeat (CPB) tick();
        rx_in = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          rs;
        cyc        = 0;
        n_cmp      = 0;
        n_err      = 0;
        rand_ready = 1'b0;
        m_data     = '0;
        model_clear();
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        ready_in = 1'b0;

        // Reset state
        tick();
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        idle(4);

        // 0xA5 with consumer ready
        ready_in = 1'b1;
        send_frame(8'hA5, 1'b1);
        idle(10);

        // Start-bit glitch
        rx_in = 1'b0;
        tick();
        idle(12);

        // Frame error on 0x3C
        send_frame(8'h3C, 1'b0);
        idle(10);

        // Back-to-back with consumer stalled: overrun on the second frame
        ready_in = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        idle(4);

        // Pop coincides with the second word loading
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        idle(4);
        ready_in = 1'b1;
        idle(4);

        // Reset mid-DATA with a full buffer, then a clean 0xFF
        ready_in = 1'b0;
        send_frame(8'h5A, 1'b1);
        idle(6);
        rx_in = 1'b0;
        repeat (14) tick();
        rx_in = 1'b1;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_data_out",  {24'd0, data_out},  32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun",   {31'd0, overrun},   32'd0);
        repeat (2) tick();
        check("rst_hold_data_out", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        idle(5);
        ready_in = 1'b1;
        send_frame(8'hFF, 1'b1);
        idle(10);

        // Randomized traffic with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            rd = DW'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rd, rs);
            if (!(rs && $urandom_range(0, 2) == 0)) idle(10 + $urandom_range(0, 6));
        end
        rand_ready = 1'b0;
        ready_in   = 1'b1;
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_rx
